// File: rtl/ascon_perm_engine.sv
`default_nettype none
// ascon_perm_engine: Ascon p^a / p^b permutation with begin/end XOR,
// start/done handshake and UNROLL rounds computed per clock.
module ascon_perm_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic         load_state_i,
  input  logic [319:0] state_i,
  input  logic [127:0] key_i,
  input  logic [63:0]  data_i,
  input  logic         en_xor_data_begin_i,
  input  logic         en_xor_key_begin_i,
  input  logic         en_xor_lsb_end_i,
  input  logic         en_xor_key_end_i,
  input  logic         capture_tag_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [319:0] state_o,
  output logic [63:0]  cipher_o,
  output logic         cipher_valid_o,
  output logic [127:0] tag_o,
  output logic         tag_valid_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1, 2, 3 or 6");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2 = x2 ^ {56'h0, 4'hF - r, r};
    // Bit-sliced 5-bit S-box
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q;
  logic [319:0] st_q;
  logic [127:0] key_q;
  logic         lsb_end_q, key_end_q, cap_q;
  logic         done_q;
  logic [63:0]  cipher_q;
  logic         cipher_valid_q;
  logic [127:0] tag_q;
  logic         tag_valid_q;

  logic         accept, active, last_grp;
  logic [3:0]   rnd_cur;
  logic [127:0] key_cur;
  logic         lsb_cur, key_end_cur, cap_cur;
  logic [319:0] begin_st, grp_in, end_st;
  logic [319:0] chain [UNROLL+1];

  // Start-cycle controls come straight from the inputs; later groups use latched copies.
  always_comb begin
    accept      = (fsm_q == IDLE) && start_i;
    active      = accept || (fsm_q == RUN);
    rnd_cur     = rnd_q;
    key_cur     = key_q;
    lsb_cur     = lsb_end_q;
    key_end_cur = key_end_q;
    cap_cur     = cap_q;
    if (accept) begin
      rnd_cur     = mode_i ? 4'd6 : 4'd0;
      key_cur     = key_i;
      lsb_cur     = en_xor_lsb_end_i;
      key_end_cur = en_xor_key_end_i;
      cap_cur     = capture_tag_i;
    end
    begin_st = load_state_i ? state_i : st_q;
    if (en_xor_data_begin_i) begin
      begin_st[319:256] = begin_st[319:256] ^ data_i;
    end
    if (en_xor_key_begin_i) begin
      begin_st[255:192] = begin_st[255:192] ^ key_i[127:64];
      begin_st[191:128] = begin_st[191:128] ^ key_i[63:0];
    end
    grp_in   = accept ? begin_st : st_q;
    last_grp = ({1'b0, rnd_cur} + 5'(UNROLL)) == 5'd12;
  end

  assign chain[0] = grp_in;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    assign chain[i+1] = ascon_round(chain[i], rnd_cur + 4'(i));
  end

  always_comb begin
    end_st = chain[UNROLL];
    if (last_grp) begin
      if (lsb_cur) begin
        end_st[0] = ~end_st[0];
      end
      if (key_end_cur) begin
        end_st[127:64] = end_st[127:64] ^ key_cur[127:64];
        end_st[63:0]   = end_st[63:0]   ^ key_cur[63:0];
      end
    end
    fsm_d = fsm_q;
    if (active) begin
      fsm_d = last_grp ? IDLE : RUN;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      rnd_q          <= 4'd0;
      st_q           <= '0;
      key_q          <= '0;
      lsb_end_q      <= 1'b0;
      key_end_q      <= 1'b0;
      cap_q          <= 1'b0;
      done_q         <= 1'b0;
      cipher_q       <= '0;
      cipher_valid_q <= 1'b0;
      tag_q          <= '0;
      tag_valid_q    <= 1'b0;
    end else begin
      done_q <= active && last_grp;
      if (active) begin
        st_q  <= end_st;
        rnd_q <= rnd_cur + 4'(UNROLL);
      end
      if (accept) begin
        key_q          <= key_i;
        lsb_end_q      <= en_xor_lsb_end_i;
        key_end_q      <= en_xor_key_end_i;
        cap_q          <= capture_tag_i;
        cipher_valid_q <= en_xor_data_begin_i;
        tag_valid_q    <= 1'b0;
        if (en_xor_data_begin_i) begin
          cipher_q <= begin_st[319:256];
        end
      end
      // A final-edge capture overrides the clear from the same accepted start.
      if (active && last_grp && cap_cur) begin
        tag_q       <= end_st[127:0];
        tag_valid_q <= 1'b1;
      end
    end
  end

  assign busy_o         = (fsm_q == RUN);
  assign done_o         = done_q;
  assign state_o        = st_q;
  assign cipher_o       = cipher_q;
  assign cipher_valid_o = cipher_valid_q;
  assign tag_o          = tag_q;
  assign tag_valid_o    = tag_valid_q;

endmodule
`default_nettype wire

// File: doc/ascon_perm_engine.md
# ascon_perm_engine

Multi-round Ascon permutation engine with round counter, start/done handshake, and configurable unrolling. It sits between the Ascon-128 control FSM and the state storage. It applies the begin XOR (data/key), then runs p^a (12 rounds) or p^b (6 rounds) internally at UNROLL rounds per clock, then applies the end XOR (domain LSB/key). It captures ciphertext and tag into registered outputs. The controller issues one `start_i` per permutation instead of sequencing each round itself.

## Interface
- UNROLL, default 1: rounds computed per clock. Legal values are 1, 2, 3, 6. Any other value is an elaboration `$error`.
- clock_i  in  1  single clock; all state updates on the rising edge.
- resetb_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a permutation. Accepted only when `busy_o`=0.
- mode_i  in  1  0: p^a (12 rounds, indices 0..11). 1: p^b (6 rounds, indices 6..11).
- load_state_i  in  1  at start: 1 takes `state_i` as the source; 0 takes the internal state register.
- state_i  in  320  external state, S0 = [319:256] … S4 = [63:0].
- key_i  in  128  key; sampled at start.
- data_i  in  64  associated data or plaintext block; sampled at start.
- en_xor_data_begin_i, en_xor_key_begin_i, en_xor_lsb_end_i, en_xor_key_end_i  in  1 each  XOR enables; sampled at start.
- capture_tag_i  in  1  at start: capture the tag when this permutation finishes.
- busy_o  out  1  a permutation is in progress.
- done_o  out  1  one-cycle pulse when the final state is valid.
- state_o  out  320  state register.
- cipher_o  out  64  S0 after the begin XOR; `cipher_valid_o` is its valid flag.
- tag_o  out  128  {S3,S4} after the end XOR; `tag_valid_o` is its valid flag.

## Operation
- FSM has two states, IDLE and RUN. Round counter `rnd` is 4 bits and holds the absolute round index 0..11.
- Start acceptance, IDLE with `start_i`=1:
  - Latch mode, all enables, `capture_tag_i`, and key.
  - `rnd` starts at 0 (p^a) or 6 (p^b).
- Begin XOR is combinational on the source state, start cycle only:
  - data enable: S0 ^= data_i.
  - key enable: S1 ^= key[127:64], S2 ^= key[63:0].
- One round r, in order:
  - Pc: S2[7:0] ^= {4'hF − r, r[3:0]}.
  - Ps: 5-bit Ascon S-box across bit-slices.
  - Pl: linear diffusion, with rotations
    - S0 (19,28)
    - S1 (61,39)
    - S2 (1,6)
    - S3 (10,17)
    - S4 (7,41)
- Each edge, UNROLL rounds r, r+1, … are chained combinationally and `rnd` += UNROLL.
- End XOR is applied only on the edge that writes the final round group (the group ending at r=11):
  - lsb enable: S4 ^= 64'h1.
  - key enable: S3 ^= key[127:64], S4 ^= key[63:0].
  - The end XOR uses the latched key.
- Cipher: on the start edge, if data enable is set, `cipher_o` <= S0 after the begin XOR and `cipher_valid_o` <= 1. Otherwise `cipher_valid_o` <= 0.
- Tag: on the final edge, if `capture_tag_i` was latched, `tag_o` <= {S3,S4} after the end XOR and `tag_valid_o` <= 1. `tag_valid_o` clears on the next accepted start.
- `start_i` while `busy_o`=1 is ignored; no queuing.
- `start_i` in the same cycle as `done_o` is accepted, because the FSM is already IDLE.
- `key_i` and `data_i` may change after the start edge without effect.

## Timing
- Reset, asynchronous: `busy_o`=0, `done_o`=0, `state_o`=0, `cipher_o`=0, `cipher_valid_o`=0, `tag_o`=0, `tag_valid_o`=0, `rnd`=0, FSM=IDLE.
- Latency: let G = N/UNROLL with N = 12 or 6.
  - The start edge applies the begin XOR and the first group.
  - The final state is in `state_o` after G edges.
  - `done_o`=1 during the cycle after edge G, for exactly one cycle.
  - `busy_o`=1 from after the start edge until edge G, so it is high for G−1 cycles.
  - Special case: with p^b and UNROLL=6, G=1 and `busy_o` is never asserted; `done_o` pulses in the next cycle.
- Worked example, p^a with UNROLL=1: start sampled at edge 0, `done_o` high in cycle 12.
- Reset asserted mid-RUN: immediate abort to reset values, no `done_o`, no tag capture.

## Test plan
- UNROLL=1, p^a, `load_state_i`=1, `state_i`={64'h80400c0600000000, K, N} with K=N=128'h000102…0F, `en_xor_key_end_i`=1 → `done_o` exactly 12 cycles after start; `state_o` equals the software Ascon-128 initialization model.
- Same stimulus at UNROLL=2, 3, 6 → identical `state_o`; `done_o` after 6, 4, 2 cycles.
- p^b with `en_xor_data_begin_i`=1, data_i=64'h0123456789ABCDEF → `cipher_o` = S0^data in the cycle after start, `cipher_valid_o`=1; the first round constant applied is 8'h96; `done_o` after 6/UNROLL cycles.
- Finalization: `en_xor_key_begin_i`=1, `en_xor_key_end_i`=1, `capture_tag_i`=1 → `tag_o` matches the model with `tag_valid_o`=1; the next start with `capture_tag_i`=0 clears `tag_valid_o`.
- `start_i` held high through a run → exactly one permutation per accept; a start in the `done_o` cycle begins a new run with no gap cycle.
- `resetb_i` pulsed low at round 5 → all outputs 0 asynchronously; no `done_o`; a following start runs normally.
